imm_decode_stage: RTL and testbench

//  Registered, elastic immediate-decode stage between fetch and execute.
//  - Accepts {instruction, pc} over valid/ready.
//  - Emits the sign-extended XLEN immediate plus a format code, pc and rd/rs1/rs2.
//  - Built-in 2-entry skid buffer: in_ready is registered, never combinational from out_ready.
//  - Supports flush for branch/jump redirects.

---
 rtl/imm_pkg.sv | 43 ++++
 rtl/imm_extract_comb.sv | 67 ++++++
 rtl/imm_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_imm_decode_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate-decode types, opcode constants and stage entry layout (IMM_ZICSR_EN adds csr field)
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_Z
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Entry fields are sized for the widest legal configuration; the top
  // slices them down to XLEN / PC_W at its ports.
  localparam int IMM_MAX_W = 64;
  localparam int PC_MAX_W  = 64;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    imm_fmt_e             fmt;
    logic [PC_MAX_W-1:0]  pc;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic                 illegal;
`ifdef IMM_ZICSR_EN
    logic [11:0]          csr;
`endif
  } dec_entry_t;

endpackage

// File: rtl/imm_extract_comb.sv
// rtl/imm_extract_comb.sv - combinational RV32I immediate extractor (IMM_ZICSR_EN enables FMT_Z)
module imm_extract_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  // Select the immediate layout from the opcode; R-type is legal with no immediate.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_REG: begin
        fmt = FMT_NONE;
      end
      OP_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        if (instr[14:12] != 3'b000) begin
          fmt   = FMT_Z;
          imm32 = {27'b0, instr[19:15]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
`else
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // zimm has bit 31 clear, so sign extension leaves it zero-extended.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - elastic immediate-decode stage with 2-entry skid buffer (IMM_ZICSR_EN adds out_csr)
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
`ifdef IMM_ZICSR_EN
  output logic [11:0]     out_csr,
`endif
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } skid_state_e;

  skid_state_e state_q, state_d;
  dec_entry_t  head_q, tail_q, dec_entry;
  logic        in_ready_q, out_valid_q;
  logic        in_xfer, out_xfer;
  logic        load_head_in, load_head_tail, load_tail;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_extract_comb #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Assemble the decoded entry ahead of the registers so outputs come straight from flops.
  always_comb begin
    dec_entry         = '0;
    dec_entry.imm     = IMM_MAX_W'(dec_imm);
    dec_entry.fmt     = dec_fmt;
    dec_entry.pc      = PC_MAX_W'(in_pc);
    dec_entry.rd      = in_instr[11:7];
    dec_entry.rs1     = in_instr[19:15];
    dec_entry.rs2     = in_instr[24:20];
    dec_entry.illegal = dec_illegal;
`ifdef IMM_ZICSR_EN
    dec_entry.csr     = in_instr[31:20];
`endif
  end

  // Without the skid entry the stage degrades to a plain pipeline register.
  assign in_ready  = SKID_EN ? in_ready_q : (out_ready | ~out_valid_q);
  assign out_valid = out_valid_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid_q & out_ready;

  // Occupancy next-state and which register loads; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d      = ST_ONE;
          load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_head_in = 1'b1;
        end else if (in_xfer) begin
          state_d   = ST_TWO;
          load_tail = 1'b1;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_xfer) begin
          state_d        = ST_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d        = ST_EMPTY;
      load_head_in   = 1'b0;
      load_head_tail = 1'b0;
      load_tail      = 1'b0;
    end
  end

  // State register; handshake flags are derived from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Entry storage: head is the oldest entry and feeds the outputs, tail is the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (load_head_in) begin
        head_q <= dec_entry;
      end else if (load_head_tail) begin
        head_q <= tail_q;
      end
      if (load_tail) begin
        tail_q <= dec_entry;
      end
    end
  end

  assign out_imm     = head_q.imm[XLEN-1:0];
  assign out_fmt     = head_q.fmt;
  assign out_pc      = head_q.pc[PC_W-1:0];
  assign out_rd      = head_q.rd;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_illegal = head_q.illegal;
`ifdef IMM_ZICSR_EN
  assign out_csr     = head_q.csr;
`endif

  // Upper imm/pc bits are unused for narrower configurations.
  logic unused_head_bits;
  assign unused_head_bits = ^head_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - self-checking bench for imm_decode_stage (IMM_ZICSR_EN aware)
module tb_imm_decode_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_pc;
  imm_fmt_e    out_fmt;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        w_in_ready, w_out_valid, w_illegal;
  logic [63:0] w_imm;
  logic [31:0] w_pc;
  imm_fmt_e    w_fmt;
  logic [4:0]  w_rd, w_rs1, w_rs2;
`ifdef IMM_ZICSR_EN
  logic [11:0] out_csr, w_csr;
`endif

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .PC_W(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
`ifdef IMM_ZICSR_EN
    .out_csr(out_csr),
`endif
    .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .PC_W(32), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_imm), .out_fmt(w_fmt),
    .out_pc(w_pc), .out_rd(w_rd), .out_rs1(w_rs1), .out_rs2(w_rs2),
`ifdef IMM_ZICSR_EN
    .out_csr(w_csr),
`endif
    .out_illegal(w_illegal)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exit_pcs[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference immediate value computed arithmetically from the instruction fields.
  function automatic void ref_dec(input logic [31:0] ins, output longint v,
                                  output imm_fmt_e f, output logic ill);
    logic [6:0] op;
    op  = ins[6:0];
    v   = 0;
    f   = FMT_NONE;
    ill = 1'b0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        f = FMT_I;
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        f = FMT_S;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        f = FMT_B;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        f = FMT_U;
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      7'h6F: begin
        f = FMT_J;
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
          + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      7'h33: f = FMT_NONE;
      7'h73: begin
`ifdef IMM_ZICSR_EN
        if (ins[14:12] != 3'd0) begin
          f = FMT_Z;
          v = longint'(ins[19:15]);
        end else begin
          f = FMT_I;
          v = longint'(ins[31:20]);
          if (v >= 2048) v -= 4096;
        end
`else
        f = FMT_I;
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
`endif
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic check_state();
    longint   v;
    imm_fmt_e f;
    logic     ill;
    exp_t     e;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid64", 64'(w_out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      ref_dec(e.instr, v, f, ill);
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("out_imm", 64'(out_imm), 64'(v[31:0]));
      chk("out_imm64", w_imm, 64'(v));
      chk("out_fmt", 64'(out_fmt), 64'(f));
      chk("out_illegal", 64'(out_illegal), 64'(ill));
      chk("out_rd", 64'(out_rd), 64'(e.instr[11:7]));
      chk("out_rs1", 64'(out_rs1), 64'(e.instr[19:15]));
      chk("out_rs2", 64'(out_rs2), 64'(e.instr[24:20]));
`ifdef IMM_ZICSR_EN
      chk("out_csr", 64'(out_csr), 64'(e.instr[31:20]));
`endif
    end
  endtask

  // One clock: account transfers in the model, advance, then check away from the edge.
  task automatic tick();
    bit in_x, out_x;
    in_x  = (in_valid === 1'b1) && (in_ready === 1'b1);
    out_x = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (out_x) begin
      exit_pcs.push_back(out_pc);
      if (q.size() != 0) void'(q.pop_front());
    end
    if (rst || flush) q.delete();
    else if (in_x) q.push_back('{in_pc, in_instr});
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic send1(input logic [31:0] ins, input logic [31:0] pc);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_imm"}, 64'(out_imm), 64'd0);
    chk({tag, "_pc"}, 64'(out_pc), 64'd0);
    chk({tag, "_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_rs1"}, 64'(out_rs1), 64'd0);
    chk({tag, "_rs2"}, 64'(out_rs2), 64'd0);
    chk({tag, "_fmt"}, 64'(out_fmt), 64'(FMT_NONE));
    chk({tag, "_illegal"}, 64'(out_illegal), 64'd0);
  endtask

  logic [6:0] ops[12] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                          7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F, 7'h0B};

  initial begin
    logic [31:0] r;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Directed decode examples.
    send1(32'hFFF00093, 32'h10);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(out_fmt), 64'(FMT_I));
    chk("addi_rd", 64'(out_rd), 64'd1);
    tick();
    send1(32'hFE112E23, 32'h14);
    chk("sw_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("sw_fmt", 64'(out_fmt), 64'(FMT_S));
    chk("sw_rs1", 64'(out_rs1), 64'd2);
    chk("sw_rs2", 64'(out_rs2), 64'd1);
    tick();
    send1(32'hFE000CE3, 32'h18);
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFF8);
    chk("beq_fmt", 64'(out_fmt), 64'(FMT_B));
    tick();
    send1(32'hFFDFF0EF, 32'h1C);
    chk("jal_imm", 64'(out_imm), 64'hFFFFFFFC);
    chk("jal_fmt", 64'(out_fmt), 64'(FMT_J));
    chk("jal_rd", 64'(out_rd), 64'd1);
    tick();
    send1(32'h123452B7, 32'h20);
    chk("lui_imm", 64'(out_imm), 64'h12345000);
    chk("lui_fmt", 64'(out_fmt), 64'(FMT_U));
    tick();
    send1(32'h800002B7, 32'h24);
    chk("lui64_imm", w_imm, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", 64'(w_fmt), 64'(FMT_U));
    tick();
    send1(32'h0000007F, 32'h28);
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_fmt", 64'(out_fmt), 64'(FMT_NONE));
    chk("ill_imm", 64'(out_imm), 64'd0);
    tick();
    send1(32'h3402D0F3, 32'h2C);
`ifdef IMM_ZICSR_EN
    chk("csr_fmt", 64'(out_fmt), 64'(FMT_Z));
    chk("csr_imm", 64'(out_imm), 64'h5);
    chk("csr_addr", 64'(out_csr), 64'h340);
`else
    chk("csr_fmt", 64'(out_fmt), 64'(FMT_I));
    chk("csr_imm", 64'(out_imm), 64'h340);
`endif
    tick();

    // Backpressure: two accepted, third held upstream, then drained in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc = 32'h0; tick();
    in_pc = 32'h4; tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_pc = 32'h8; tick(); tick();
    exit_pcs.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bit acc;
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", 64'(exit_pcs.size()), 64'd3);
    if (exit_pcs.size() == 3) begin
      chk("bp_pc0", 64'(exit_pcs[0]), 64'h0);
      chk("bp_pc1", 64'(exit_pcs[1]), 64'h4);
      chk("bp_pc2", 64'(exit_pcs[2]), 64'h8);
    end

    // Flush with two entries held and a valid input pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pc = 32'h100; tick();
    in_pc = 32'h104; tick();
    in_pc = 32'h108; flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exit_pcs.delete();
    repeat (3) tick();
    chk("flush_nothing_out", 64'(exit_pcs.size()), 64'd0);

    // Mid-operation reset with two entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE112E23;
    in_pc = 32'h300; tick();
    in_pc = 32'h304; tick();
    rst = 1'b1; tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    in_instr = 32'hFFF00093;
    in_pc    = 32'h200;
    tick();
    in_valid = 1'b0;
    chk("postrst_valid", 64'(out_valid), 64'd1);
    chk("postrst_pc", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    tick();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      r         = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = {r[31:7], ops[$urandom_range(0, 11)]};
      if ($urandom_range(0, 11) == 0) in_instr = $urandom();
      in_pc     = $urandom();
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
